// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP, with address,
// range and width checks. Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_unit #(
   parameter int unsigned ADDR_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_base,
   input  logic [11:0] req_offset,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   output logic [2:0]  mem_mode,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, wd_reg, rdata_reg;
   logic [2:0]  mode_reg, funct3_reg;
   logic        store_reg, err_reg, resp_err_reg;

   logic        accept;
   logic [31:0] ea;
   logic [2:0]  mode_next;
   logic        legal;
   logic [2:0]  size;
   logic [32:0] ea_end;
   logic        size_err, align_err;
   logic [31:0] load_ext;

   assign accept = req_valid && req_ready;
   assign ea     = req_base + {{20{req_offset[11]}}, req_offset};

   always_comb begin
      mode_next = 3'b000;
      legal     = 1'b0;
      if (req_we) begin
         case (req_funct3)
            3'b000:  begin mode_next = 3'b010; legal = 1'b1; end
            3'b001:  begin mode_next = 3'b001; legal = 1'b1; end
            3'b010:  begin mode_next = 3'b000; legal = 1'b1; end
            default: begin mode_next = 3'b000; legal = 1'b0; end
         endcase
      end else begin
         case (req_funct3)
            3'b000:  begin mode_next = 3'b110; legal = 1'b1; end
            3'b001:  begin mode_next = 3'b101; legal = 1'b1; end
            3'b010:  begin mode_next = 3'b000; legal = 1'b1; end
            3'b100:  begin mode_next = 3'b010; legal = 1'b1; end
            3'b101:  begin mode_next = 3'b001; legal = 1'b1; end
            default: begin mode_next = 3'b000; legal = 1'b0; end
         endcase
      end
   end

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
   end

   // 33-bit end address so accesses near 2^32 cannot wrap back into range
   assign ea_end   = {1'b0, ea} + {30'd0, size};
   assign size_err = ea_end > 33'(ADDR_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
   assign align_err = ((size == 3'd2) && ea[0]) || ((size == 3'd4) && (ea[1:0] != 2'b00));
`else
   assign align_err = 1'b0;
`endif

   always_comb begin
      case (funct3_reg)
         3'b000:  load_ext = {{24{mem_rd[7]}}, mem_rd[7:0]};
         3'b001:  load_ext = {{16{mem_rd[15]}}, mem_rd[15:0]};
         3'b100:  load_ext = {24'd0, mem_rd[7:0]};
         3'b101:  load_ext = {16'd0, mem_rd[15:0]};
         default: load_ext = mem_rd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg     <= '0;
         wd_reg       <= '0;
         mode_reg     <= '0;
         funct3_reg   <= '0;
         store_reg    <= 1'b0;
         err_reg      <= 1'b0;
         rdata_reg    <= '0;
         resp_err_reg <= 1'b0;
      end else begin
         if (accept) begin
            addr_reg   <= ea;
            wd_reg     <= req_wdata;
            mode_reg   <= mode_next;
            funct3_reg <= req_funct3;
            store_reg  <= req_we;
            err_reg    <= !legal || size_err || align_err;
         end
         if (state_reg == ACCESS) begin
            resp_err_reg <= err_reg;
            rdata_reg    <= (store_reg || err_reg) ? 32'd0 : load_ext;
         end
      end
   end

   assign req_ready  = (state_reg == IDLE);
   assign resp_valid = (state_reg == RESP);
   assign resp_rdata = rdata_reg;
   assign resp_err   = resp_err_reg;
   assign mem_a      = addr_reg;
   assign mem_wd     = wd_reg;
   assign mem_mode   = mode_reg;
   // reset gates the write strobe in the same cycle so an interrupted store never lands
   assign mem_we     = (state_reg == ACCESS) && store_reg && !err_reg && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written stall/reset sequences,
// and random requests checked against a byte-array reference model.
module tb_load_store_unit;
   localparam int unsigned LIMIT = 1024;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, mem_we;
   logic [2:0]  req_funct3, mem_mode;
   logic [31:0] req_base, req_wdata, resp_rdata, mem_a, mem_wd, mem_rd;
   logic [11:0] req_offset;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0]  dmem    [0:LIMIT-1];
   logic [7:0]  ref_mem [0:LIMIT-1];
   logic [31:0] raw;

   load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_we(mem_we), .mem_mode(mem_mode), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Attached memory: combinational read extended according to mode, byte-addressed little-endian
   always_comb begin
      raw = '0;
      for (int i = 0; i < 4; i++) raw[8*i +: 8] = dmem[10'(mem_a + 32'(i))];
      case (mem_mode)
         3'b110:  mem_rd = {{24{raw[7]}}, raw[7:0]};
         3'b101:  mem_rd = {{16{raw[15]}}, raw[15:0]};
         3'b010:  mem_rd = {24'd0, raw[7:0]};
         3'b001:  mem_rd = {16'd0, raw[15:0]};
         default: mem_rd = raw;
      endcase
   end

   always @(posedge clk) begin
      if (mem_we) begin
         dmem[10'(mem_a)] <= mem_wd[7:0];
         if (mem_mode != 3'b010) dmem[10'(mem_a + 32'd1)] <= mem_wd[15:8];
         if (mem_mode == 3'b000) begin
            dmem[10'(mem_a + 32'd2)] <= mem_wd[23:16];
            dmem[10'(mem_a + 32'd3)] <= mem_wd[31:24];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: RISC-V load/store semantics straight from the width tables
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] base,
                                 input logic [11:0] off, output logic legal, output logic err,
                                 output logic [2:0] mode, output logic [31:0] a,
                                 output logic [31:0] rd);
      int size;
      bit sgn;
      longint v;
      a = base + 32'($signed(off));
      legal = 1'b1; sgn = 1'b0; size = 1; mode = 3'b000;
      if (we) begin
         case (f3)
            3'b000:  begin size = 1; mode = 3'b010; end
            3'b001:  begin size = 2; mode = 3'b001; end
            3'b010:  begin size = 4; mode = 3'b000; end
            default: legal = 1'b0;
         endcase
      end else begin
         case (f3)
            3'b000:  begin size = 1; mode = 3'b110; sgn = 1'b1; end
            3'b001:  begin size = 2; mode = 3'b101; sgn = 1'b1; end
            3'b010:  begin size = 4; mode = 3'b000; end
            3'b100:  begin size = 1; mode = 3'b010; end
            3'b101:  begin size = 2; mode = 3'b001; end
            default: legal = 1'b0;
         endcase
      end
      err = !legal || (longint'(a) + longint'(size) > longint'(LIMIT));
`ifdef LSU_MISALIGN_TRAP_EN
      if (legal && (a % size != 0)) err = 1'b1;
`endif
      rd = 32'd0;
      if (!we && !err) begin
         v = 0;
         for (int i = 0; i < size; i++) v += longint'(ref_mem[10'(a + 32'(i))]) << (8 * i);
         if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
         rd = 32'(v);
      end
   endfunction

   task automatic commit(input logic we, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] wd);
      logic legal, err;
      logic [2:0] mode;
      logic [31:0] a, rd;
      int size;
      model(we, f3, base, off, legal, err, mode, a, rd);
      size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
      if (we && !err)
         for (int i = 0; i < size; i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
   endtask

   // Runs one request starting at a negedge in IDLE; ends at a negedge back in IDLE.
   task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] base, input logic [11:0] off, input logic [31:0] wd,
                      input logic exp_err, input logic chk_mode, input logic [2:0] exp_mode,
                      input logic [31:0] exp_a, input logic [31:0] exp_rd, input int stall);
      int guard = 0;
      logic [31:0] held;
      while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_base = base;
      req_offset = off; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
      req_base = $urandom; req_offset = 12'($urandom); req_wdata = $urandom;
      @(negedge clk);
      check({tag, ".access_valid"}, 32'(resp_valid), 32'd0);
      check({tag, ".mem_we"}, 32'(mem_we), 32'(we && !exp_err));
      check({tag, ".mem_a"}, mem_a, exp_a);
      if (chk_mode) check({tag, ".mem_mode"}, 32'(mem_mode), 32'(exp_mode));
      if (we && !exp_err) check({tag, ".mem_wd"}, mem_wd, wd);
      resp_ready = (stall == 0);
      @(negedge clk);
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
      check({tag, ".resp_rdata"}, resp_rdata, exp_rd);
      check({tag, ".resp_mem_we"}, 32'(mem_we), 32'd0);
      held = resp_rdata;
      for (int i = 0; i < stall; i++) begin
         // a competing store request must be ignored while the response is pending
         req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
         req_base = 32'h0000_0300; req_offset = 12'd0;
         @(negedge clk);
         check({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
         check({tag, ".stall_rdata"}, resp_rdata, held);
         check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
         check({tag, ".stall_we"}, 32'(mem_we), 32'd0);
         check({tag, ".stall_a"}, mem_a, exp_a);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      check({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
      check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
      $display("txn %s we=%0d f3=%b a=%h err=%0d rdata=%h stall=%0d",
               tag, we, f3, mem_a, resp_err, held, stall);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] base;
      logic [11:0] off;
      logic [31:0] wd;
      logic        err;
      logic        chk_mode;
      logic [2:0]  mode;
      logic [31:0] a;
      logic [31:0] rd;
   } vec_t;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      logic legal, err;
      logic [2:0] mode;
      logic [31:0] a, rd;
      logic we;
      logic [2:0] f3;
      logic [31:0] base, wd;
      logic [11:0] off;
      int stall;

      for (int i = 0; i < LIMIT; i++) begin
         dmem[i]    = 8'(i) ^ 8'h5A;
         ref_mem[i] = 8'(i) ^ 8'h5A;
      end
      reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; req_we = 1'b0;
      req_funct3 = 3'b000; req_base = '0; req_offset = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.resp_err", 32'(resp_err), 32'd0);
      check("rst.mem_we", 32'(mem_we), 32'd0);
      check("rst.mem_a", mem_a, 32'd0);
      check("rst.mem_wd", mem_wd, 32'd0);
      check("rst.mem_mode", 32'(mem_mode), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      //            we    f3      base           off       wdata          err chk mode    addr           rdata
      vecs.push_back('{1'b1, 3'b010, 32'h0000_0100, 12'h004, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b000, 32'h0000_0104, 32'h0000_0000});
      vecs.push_back('{1'b1, 3'b000, 32'h0000_0104, 12'h000, 32'h1234_56DE, 1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'b000, 32'h0000_0100, 12'h004, 32'h0,         1'b0, 1'b1, 3'b110, 32'h0000_0104, 32'hFFFF_FFDE});
      vecs.push_back('{1'b0, 3'b100, 32'h0000_0104, 12'h000, 32'h0,         1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0000_00DE});
      vecs.push_back('{1'b0, 3'b010, 32'h0000_0104, 12'h000, 32'h0,         1'b0, 1'b1, 3'b000, 32'h0000_0104, 32'hDEAD_BEDE});
      vecs.push_back('{1'b0, 3'b001, 32'h0000_0106, 12'h000, 32'h0,         1'b0, 1'b1, 3'b101, 32'h0000_0106, 32'hFFFF_DEAD});
      vecs.push_back('{1'b0, 3'b101, 32'h0000_0106, 12'h000, 32'h0,         1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_DEAD});
      vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 12'hFF0, 32'h0,         1'b0, 1'b1, 3'b000, 32'h0000_0000, 32'h5958_5B5A});
      vecs.push_back('{1'b0, 3'b010, 32'h0000_03FE, 12'h000, 32'h0,         1'b1, 1'b1, 3'b000, 32'h0000_03FE, 32'h0000_0000});
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back('{1'b0, 3'b001, 32'h0000_0101, 12'h000, 32'h0,         1'b1, 1'b1, 3'b101, 32'h0000_0101, 32'h0000_0000});
`else
      vecs.push_back('{1'b0, 3'b001, 32'h0000_0101, 12'h000, 32'h0,         1'b0, 1'b1, 3'b101, 32'h0000_0101, 32'h0000_585B});
`endif
      vecs.push_back('{1'b0, 3'b010, 32'h0000_03FC, 12'h000, 32'h0,         1'b0, 1'b1, 3'b000, 32'h0000_03FC, 32'hA5A4_A7A6});
      vecs.push_back('{1'b0, 3'b100, 32'h0000_0400, 12'hFFF, 32'h0,         1'b0, 1'b1, 3'b010, 32'h0000_03FF, 32'h0000_00A5});
      vecs.push_back('{1'b0, 3'b001, 32'h0000_03FF, 12'h000, 32'h0,         1'b1, 1'b1, 3'b101, 32'h0000_03FF, 32'h0000_0000});
      vecs.push_back('{1'b1, 3'b000, 32'h0000_0400, 12'h000, 32'h0000_0011, 1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'b100, 32'hFFFF_FFFF, 12'h001, 32'h0,         1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h0000_005A});
      vecs.push_back('{1'b0, 3'b010, 32'hFFFF_FFFC, 12'h000, 32'h0,         1'b1, 1'b1, 3'b000, 32'hFFFF_FFFC, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'b011, 32'h0000_0000, 12'h000, 32'h0,         1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{1'b1, 3'b100, 32'h0000_0200, 12'h000, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'h0000_0000});
      vecs.push_back('{1'b1, 3'b101, 32'h0000_0200, 12'h000, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'b000, 32'h0000_0200, 12'h000, 32'h0,         1'b0, 1'b1, 3'b110, 32'h0000_0200, 32'h0000_005A});
      vecs.push_back('{1'b1, 3'b001, 32'h0000_0200, 12'h002, 32'hFFFF_8081, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'b001, 32'h0000_0202, 12'h000, 32'h0,         1'b0, 1'b1, 3'b101, 32'h0000_0202, 32'hFFFF_8081});

      foreach (vecs[i]) begin
         txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].base, vecs[i].off,
             vecs[i].wd, vecs[i].err, vecs[i].chk_mode, vecs[i].mode, vecs[i].a, vecs[i].rd, 0);
         commit(vecs[i].we, vecs[i].f3, vecs[i].base, vecs[i].off, vecs[i].wd);
      end

      // Response held back for five cycles while a competing request is presented
      model(1'b0, 3'b010, 32'h0000_0100, 12'h004, legal, err, mode, a, rd);
      txn("stall5", 1'b0, 3'b010, 32'h0000_0100, 12'h004, 32'h0, err, legal, mode, a, rd, 5);
      check("stall5.ignored_store", 32'(dmem[10'h300]), 32'(ref_mem[10'h300]));

      // Reset arriving while a store is in ACCESS
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_base = 32'h0000_0280; req_offset = 12'd0; req_wdata = 32'h0000_0077;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_access.mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_access.resp_valid", 32'(resp_valid), 32'd0);
      check("rst_access.req_ready", 32'(req_ready), 32'd1);
      check("rst_access.mem_a", mem_a, 32'd0);
      check("rst_access.mem_byte", 32'(dmem[10'h280]), 32'(ref_mem[10'h280]));
      $display("txn rst_access store a=00000280 aborted by reset");
      model(1'b0, 3'b100, 32'h0000_0280, 12'h000, legal, err, mode, a, rd);
      txn("rst_access.load", 1'b0, 3'b100, 32'h0000_0280, 12'h000, 32'h0, err, legal, mode, a, rd, 0);

      for (int n = 0; n < 160; n++) begin
         we    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         base  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         off   = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
         wd    = $urandom;
         stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         model(we, f3, base, off, legal, err, mode, a, rd);
         txn($sformatf("rnd%0d", n), we, f3, base, off, wd, err, legal, mode, a, rd, stall);
         commit(we, f3, base, off, wd);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 1024, giving the number of bytes in the attached data memory.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  the core presents a request.
REQ-005 SHALL have port req_ready  output  1  the unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width/sign code.
REQ-008 SHALL have port req_base  input  32  base address.
REQ-009 SHALL have port req_offset  input  12  signed byte offset.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  the response is available.
REQ-012 SHALL have port resp_ready  input  1  the core consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  load result, already extended.
REQ-014 SHALL have port resp_err  output  1  the access was rejected.
REQ-015 SHALL have ports mem_a (output, 32), mem_wd (output, 32), mem_we (output, 1) and mem_mode (output, 3), which drive the memory port.
REQ-016 SHALL have port mem_rd  input  32  memory read data; it is combinational on mem_a and mem_mode.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS and RESP.
- IDLE -> ACCESS on req_valid && req_ready.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE when resp_ready is 1.
REQ-018 SHALL drive req_ready to 1 only in IDLE; resp_valid SHALL be 1 only in RESP, and resp_rdata/resp_err SHALL stay stable until the response is consumed.
REQ-019 SHALL, on accept, register the effective address = req_base + sign-extended req_offset, computed modulo 2^32 (wrap-around permitted).
REQ-020 SHALL map load funct3 to mem_mode as follows:
- 000 -> 110
- 001 -> 101
- 010 -> 000
- 100 -> 010
- 101 -> 001
REQ-021 SHALL map store funct3 to mem_mode as follows:
- 000 -> 010
- 001 -> 001
- 010 -> 000
REQ-022 SHALL treat any other funct3 as illegal: resp_err = 1.
REQ-023 SHALL flag resp_err = 1 when address + access size > ADDR_LIMIT; the size is 1, 2 or 4 bytes.
REQ-024 SHALL, in ACCESS, drive mem_a/mem_mode/mem_wd from the registered request, and assert mem_we for exactly that one cycle only for an error-free store.
REQ-025 SHALL capture mem_rd into resp_rdata at the end of ACCESS for an error-free load; for stores and errored accesses, resp_rdata SHALL be 0.
REQ-026 SHALL hold mem_we = 0 in IDLE and RESP; in those states mem_a, mem_mode and mem_wd SHALL hold their last values.
REQ-027 SHALL give an accept-to-resp_valid latency of exactly 2 cycles; back-to-back throughput is one request per 3 cycles when resp_ready is tied high.
REQ-028 SHALL ignore req_valid outside IDLE; the request inputs are sampled only on accept.

Reset
REQ-029 SHALL, on reset, force the state to IDLE and drive outputs as follows:
- req_ready = 1 in the following cycle
- resp_valid = 0
- resp_rdata = 0
- resp_err = 0
- mem_we = 0
- mem_a = 0
- mem_wd = 0
- mem_mode = 000
REQ-030 SHALL have reset take priority over every transition: reset asserted during ACCESS suppresses mem_we that cycle and discards the response.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, flag resp_err = 1 and suppress mem_we for:
- a halfword access at an odd address
- a word access with address[1:0] != 0
REQ-032 SHALL, without LSU_MISALIGN_TRAP_EN, pass misaligned accesses to memory unchanged; range and illegal-funct3 checks remain active.

Verification
REQ-033 SHALL cover: reset, then an SW with base 0x100, offset 0x004, wdata 0xDEADBEEF -> mem_we is high for one cycle with mem_a 0x104 and mem_mode 000; resp_err = 0 and resp_rdata = 0.
REQ-034 SHALL cover: an LB from 0x104 with memory byte 0xDE -> resp_rdata 0xFFFFFFDE; an LBU from the same address -> 0x000000DE; resp_valid is seen 2 cycles after accept.
REQ-035 SHALL cover: base 0x10, offset 0xFF0 (-16) -> mem_a 0x0; base 0x3FE with an LW -> resp_err = 1, no mem_we, resp_rdata 0.
REQ-036 SHALL cover: an LH at 0x101 -> resp_err = 1 with LSU_MISALIGN_TRAP_EN defined; with the macro undefined -> resp_err = 0 and mem_mode 101.
REQ-037 SHALL cover: a response with resp_ready held at 0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready stays 0, and a new req_valid is ignored until resp_ready is 1.
REQ-038 SHALL cover: reset asserted in ACCESS for a store -> mem_we stays 0, no resp_valid, and the unit is in IDLE on the next cycle.
